// File: rtl/lapido_if_stage_pkg.sv
// Shared constants and types for the core_lapido instruction-fetch stage.
package lapido_if_stage_pkg;

  localparam int unsigned DefPcWidth = 16;
  localparam int unsigned DefResetPc = 0;
  localparam logic [31:0] NopInstr   = 32'h0000_0000;

  typedef enum logic [1:0] {
    CycFetch,
    CycStall,
    CycRedirect
  } cyc_e;

  // A WB redirect always wins over an ID stall.
  function automatic cyc_e cycle_kind(input logic redirect, input logic stall);
    if (redirect) return CycRedirect;
    if (stall) return CycStall;
    return CycFetch;
  endfunction

endpackage

// File: rtl/lapido_if_stage_if.sv
// Fetch-stage bus: WB redirect, ID stall, instruction memory port and IF/ID register.
interface lapido_if_stage_if
  import lapido_if_stage_pkg::*;
#(
  parameter int unsigned PC_WIDTH = DefPcWidth
);
  logic                stall;
  logic                wb_is_jump;
  logic [PC_WIDTH-1:0] wb_jump_addr;
  logic                wb_branch_taken;
  logic [PC_WIDTH-1:0] wb_branch_addr;
  logic                imem_en;
  logic [PC_WIDTH-1:0] imem_addr;
  logic [31:0]         imem_rdata;
  logic [31:0]         if_id_instruction;
  logic [PC_WIDTH-1:0] if_id_next_pc;
  logic                if_id_valid;

  modport master (
    input  stall, wb_is_jump, wb_jump_addr, wb_branch_taken, wb_branch_addr, imem_rdata,
    output imem_en, imem_addr, if_id_instruction, if_id_next_pc, if_id_valid
  );

  modport slave (
    output stall, wb_is_jump, wb_jump_addr, wb_branch_taken, wb_branch_addr, imem_rdata,
    input  imem_en, imem_addr, if_id_instruction, if_id_next_pc, if_id_valid
  );
endinterface

// File: rtl/lapido_if_hold_buf.sv
// One-entry skid buffer that parks the in-flight fetch word while ID is stalled.
module lapido_if_hold_buf
  import lapido_if_stage_pkg::*;
#(
  parameter int unsigned PC_WIDTH = DefPcWidth
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                capture,
  input  logic                drain,
  input  logic [31:0]         cap_instr,
  input  logic [PC_WIDTH-1:0] cap_pc,
  output logic                valid,
  output logic [31:0]         instr,
  output logic [PC_WIDTH-1:0] pc
);

  logic                valid_q;
  logic [31:0]         instr_q;
  logic [PC_WIDTH-1:0] pc_q;

  // Capture beats drain: the returning word refills the slot being emptied.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      instr_q <= NopInstr;
      pc_q    <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (capture) begin
      valid_q <= 1'b1;
      instr_q <= cap_instr;
      pc_q    <= cap_pc;
    end else if (drain) begin
      valid_q <= 1'b0;
    end
  end

  assign valid = valid_q;
  assign instr = instr_q;
  assign pc    = pc_q;

  no_overwrite_a: assert property (@(posedge clk) disable iff (!rst)
    (capture && !flush) |-> (!valid_q || drain));

endmodule

// File: rtl/lapido_if_stage.sv
// Instruction-fetch stage: PC register, redirect mux, 1-cycle imem read and IF/ID register.
module lapido_if_stage
  import lapido_if_stage_pkg::*;
#(
  parameter int unsigned         PC_WIDTH = DefPcWidth,
  parameter logic [PC_WIDTH-1:0] RESET_PC = PC_WIDTH'(DefResetPc)
) (
  input logic               clk,
  input logic               rst,
  lapido_if_stage_if.master bus
);

  typedef logic [PC_WIDTH-1:0] pc_t;

  logic        redirect;
  pc_t         target;
  cyc_e        cyc;
  pc_t         pc_q;
  pc_t         req_pc_q;
  logic        req_valid_q;
  logic        hold_valid;
  logic        hold_capture;
  logic        hold_drain;
  logic [31:0] hold_instr;
  pc_t         hold_pc;
  logic [31:0] instr_q;
  pc_t         next_pc_q;
  logic        valid_q;

  always_comb begin
    redirect     = bus.wb_is_jump | bus.wb_branch_taken;
    target       = bus.wb_is_jump ? bus.wb_jump_addr : bus.wb_branch_addr;
    cyc          = cycle_kind(redirect, bus.stall);
    // A returning word goes to the hold slot whenever it cannot go straight to ID.
    hold_capture = req_valid_q &&
                   ((cyc == CycStall) || (cyc == CycFetch && hold_valid));
    hold_drain   = (cyc == CycFetch) && hold_valid;
  end

  assign bus.imem_en   = redirect | ~bus.stall;
  assign bus.imem_addr = redirect ? target : pc_q;

  lapido_if_hold_buf #(
    .PC_WIDTH (PC_WIDTH)
  ) u_hold_buf (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect),
    .capture   (hold_capture),
    .drain     (hold_drain),
    .cap_instr (bus.imem_rdata),
    .cap_pc    (req_pc_q),
    .valid     (hold_valid),
    .instr     (hold_instr),
    .pc        (hold_pc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q        <= RESET_PC;
      req_pc_q    <= '0;
      req_valid_q <= 1'b0;
      instr_q     <= NopInstr;
      next_pc_q   <= '0;
      valid_q     <= 1'b0;
    end else begin
      unique case (cyc)
        CycRedirect: begin
          pc_q        <= target + PC_WIDTH'(1);
          req_valid_q <= 1'b1;
          req_pc_q    <= target;
          valid_q     <= 1'b0;
          instr_q     <= NopInstr;
        end
        CycFetch: begin
          pc_q        <= pc_q + PC_WIDTH'(1);
          req_valid_q <= 1'b1;
          req_pc_q    <= pc_q;
          if (hold_valid) begin
            instr_q   <= hold_instr;
            next_pc_q <= hold_pc + PC_WIDTH'(1);
            valid_q   <= 1'b1;
          end else if (req_valid_q) begin
            instr_q   <= bus.imem_rdata;
            next_pc_q <= req_pc_q + PC_WIDTH'(1);
            valid_q   <= 1'b1;
          end else begin
            valid_q   <= 1'b0;
          end
        end
        CycStall: begin
          req_valid_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.if_id_instruction = instr_q;
  assign bus.if_id_next_pc     = next_pc_q;
  assign bus.if_id_valid       = valid_q;

endmodule

// File: tb/tb_lapido_if_stage.sv
// Directed bench for lapido_if_stage with a 1-cycle-latency imem model (word = addr ^ A5A5_0000).
module tb_lapido_if_stage;
  import lapido_if_stage_pkg::*;

  localparam int unsigned W = DefPcWidth;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_bad;
  logic saw_20;

  lapido_if_stage_if #(.PC_WIDTH(W)) bus ();

  lapido_if_stage #(.PC_WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.imem_en) begin
      bus.imem_rdata <= {{(32 - W){1'b0}}, bus.imem_addr} ^ 32'hA5A5_0000;
      if (bus.imem_addr == W'(32'h20)) saw_20 <= 1'b1;
    end
  end

  function automatic logic [31:0] word(input int unsigned a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input int unsigned a, input int unsigned npc);
    check({tag, ".valid"}, 32'(bus.if_id_valid), 32'd1);
    check({tag, ".instr"}, bus.if_id_instruction, word(a));
    check({tag, ".next_pc"}, 32'(bus.if_id_next_pc), npc);
  endtask

  task automatic check_bubble(input string tag);
    check({tag, ".valid"}, 32'(bus.if_id_valid), 32'd0);
    check({tag, ".instr"}, bus.if_id_instruction, NopInstr);
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    saw_20 = 1'b0;
    rst = 1'b0;
    bus.stall = 1'b0;
    bus.wb_is_jump = 1'b0;
    bus.wb_jump_addr = '0;
    bus.wb_branch_taken = 1'b0;
    bus.wb_branch_addr = '0;
    bus.imem_rdata = 32'hDEAD_BEEF;
    step();
    step();
    check_bubble("reset");
    check("reset.next_pc", 32'(bus.if_id_next_pc), 32'd0);
    check("reset.imem_addr", 32'(bus.imem_addr), 32'd0);

    // Free run from reset: addr 0 lands two edges after release.
    rst = 1'b1;
    step();
    check("boot.bubble", 32'(bus.if_id_valid), 32'd0);
    for (int a = 0; a <= 4; a++) begin
      step();
      check_out($sformatf("run%0d", a), a, a + 1);
    end

    // Stall while addr 5 is in flight.
    bus.stall = 1'b1;
    #1;
    check("stall.imem_en", 32'(bus.imem_en), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check_out($sformatf("stall%0d", i), 4, 5);
      check("stall.imem_en_hold", 32'(bus.imem_en), 32'd0);
    end
    bus.stall = 1'b0;
    step();
    check_out("unstall5", 5, 6);
    step();
    check_out("unstall6", 6, 7);

    // Jump to 0x40.
    bus.wb_is_jump = 1'b1;
    bus.wb_jump_addr = W'(32'h40);
    #1;
    check("jmp.imem_addr", 32'(bus.imem_addr), 32'h40);
    check("jmp.imem_en", 32'(bus.imem_en), 32'd1);
    step();
    bus.wb_is_jump = 1'b0;
    check_bubble("jmp.bubble");
    step();
    check_out("jmp.target", 32'h40, 32'h41);

    // Jump and branch together: jump wins.
    bus.wb_is_jump = 1'b1;
    bus.wb_jump_addr = W'(32'h80);
    bus.wb_branch_taken = 1'b1;
    bus.wb_branch_addr = W'(32'h20);
    #1;
    check("prio.imem_addr", 32'(bus.imem_addr), 32'h80);
    step();
    bus.wb_is_jump = 1'b0;
    bus.wb_branch_taken = 1'b0;
    check_bubble("prio.bubble");
    step();
    check_out("prio.target", 32'h80, 32'h81);
    check("prio.no_0x20", 32'(saw_20), 32'd0);

    // Branch during a stall with the hold buffer full (holds 0x81).
    bus.stall = 1'b1;
    step();
    check_out("bstall.hold", 32'h80, 32'h81);
    bus.wb_branch_taken = 1'b1;
    bus.wb_branch_addr = W'(32'h10);
    #1;
    check("bstall.imem_en", 32'(bus.imem_en), 32'd1);
    check("bstall.imem_addr", 32'(bus.imem_addr), 32'h10);
    step();
    bus.wb_branch_taken = 1'b0;
    bus.stall = 1'b0;
    check_bubble("bstall.bubble");
    step();
    check_out("bstall.target", 32'h10, 32'h11);
    step();
    check_out("bstall.flushed", 32'h11, 32'h12);

    // PC wrap at the top of the address space.
    bus.wb_is_jump = 1'b1;
    bus.wb_jump_addr = '1;
    step();
    bus.wb_is_jump = 1'b0;
    #1;
    check("wrap.imem_addr", 32'(bus.imem_addr), 32'd0);
    step();
    check_out("wrap.last", (1 << W) - 1, 0);
    step();
    check_out("wrap.zero", 0, 1);

    // Asynchronous reset mid-stream.
    #2;
    rst = 1'b0;
    #1;
    check_bubble("midrst");
    check("midrst.next_pc", 32'(bus.if_id_next_pc), 32'd0);
    check("midrst.imem_addr", 32'(bus.imem_addr), 32'd0);
    step();
    check_bubble("midrst.held");
    rst = 1'b1;
    step();
    check("restart.bubble", 32'(bus.if_id_valid), 32'd0);
    step();
    check_out("restart0", 0, 1);
    step();
    check_out("restart1", 1, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
